alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
Shares one combinational ALU (op codes ADD=00, SUB=01, AND=10, OR=11) between two requesters, r0 and r1. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, latches the winner's operands and op, and drives the shared ALU from those registers. It captures the ALU result and holds it on the winner's response channel until that requester accepts it. Exactly one transaction is in flight at a time.

Parameters:
WIDTH, 32, operand/result width; the ALU port widths match it.
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with r0 winning.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
r0_valid  input  1  r0 request valid
r0_ready  output  1  r0 request accepted this cycle
r0_a  input  WIDTH  r0 operand A
r0_b  input  WIDTH  r0 operand B
r0_op  input  2  r0 ALU op
r0_rsp_valid  output  1  r0 result valid
r0_rsp_ready  input  1  r0 consumes the result
r0_rsp_out  output  WIDTH  r0 result
r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_rsp_valid, r1_rsp_ready, r1_rsp_out: same as the r0 ports, for r1
alu_a  output  WIDTH  to the shared ALU A input
alu_b  output  WIDTH  to the shared ALU B input
alu_op  output  2  to the shared ALU op input
alu_out  input  WIDTH  from the shared ALU result
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE, priority pointer=r0, grant id=0.
  - Operand/op registers=0, so alu_a=alu_b=0 and alu_op=00.
  - Result register=0.
  - All *_ready, *_rsp_valid and busy are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from r0_valid, r1_valid and the pointer.
  - If only one requester is valid, it wins regardless of the pointer.
  - If both are valid, the pointer's requester wins (with RR_EN=0, r0 wins).
  - The winner's rN_ready=1 in the same cycle; the loser's ready stays 0.
  - On handshake: latch a, b, op and the grant id; go to EXEC.
  - With no valid input, stay in IDLE; both ready=0.
- EXEC (one cycle):
  - alu_a, alu_b and alu_op are driven from the latched registers.
  - Capture alu_out into the result register; go to RESP.
- RESP:
  - The granted requester's rsp_valid=1 and rsp_out=result register; the other channel has rsp_valid=0.
  - rsp_out must stay stable while rsp_valid is high.
  - Stay in RESP until the granted rsp_ready=1.
  - On the rsp_valid & rsp_ready cycle: set the pointer to the non-granted requester (RR_EN=1 only) and go to IDLE.
- Latency:
  - Request handshake at cycle T → rsp_valid high from cycle T+2.
  - With rsp_ready held high, the next accept is possible at T+3, so peak throughput is 1 op per 3 cycles.
- *_ready and *_rsp_valid are both 0 in EXEC; all request ready outputs are 0 in EXEC and RESP.
- Operands and op are sampled only at the handshake. Input changes or valid drop after acceptance have no effect.
- The pointer updates only on response completion, never on a grant.
- Arithmetic:
  - All results are modulo 2^WIDTH, with no carry or overflow output.
  - SUB computes A−B in two's complement; e.g. 3−5 = 0xFFFFFFFE at WIDTH=32.
- rsp_ready asserted by the non-granted requester, or while not in RESP, is ignored.
- A new request may be presented on the same cycle the previous response completes. It is not accepted until the following cycle, in IDLE.
- rst mid-transaction (EXEC or RESP): the transaction is dropped with no response, and all outputs return to their reset values on the next edge.
- alu_* outputs always reflect the latched registers; they hold their last value in IDLE and RESP.

Test Plan:
- Single op: r0 sends A=7, B=5, op=SUB at T, with rsp_ready=1 → r0_ready=1 at T; alu_op=01 at T+1; r0_rsp_valid=1 with r0_rsp_out=2 at T+2; busy=0 at T+3.
- Simultaneous contention, RR_EN=1, after reset: r0 ADD 1+2 and r1 OR 0xF0|0x0F, both held valid → r0 is served first (out=3), then r1 (out=0xFF), then r0 again. Grants alternate with no back-to-back repeat while both stay valid.
- Backpressure: r1 AND 0xFFFF0000 & 0x12345678 with r1_rsp_ready=0 for 5 cycles → rsp_valid stays high and rsp_out=0x12340000 is stable; r0_ready=0 throughout even with r0_valid=1; completion on the first rsp_ready=1 cycle.
- Wrap-around: ADD 0xFFFFFFFF+1 → 0; SUB 0−1 → 0xFFFFFFFF.
- Operand stability: after r0's handshake, change r0_a/r0_b/r0_op on the next cycle → the result reflects the values captured at the handshake.
- Reset mid-op: assert rst in RESP with rsp_ready=0 → the next cycle shows rsp_valid=0, busy=0, alu_a=alu_b=0, pointer=r0; a fresh request then completes normally.

Source files
------------

// File: rtl/alu_scheduler.sv
// Two-requester front end for one shared combinational ALU: arbitrates, latches
// the winning request, captures the ALU result and returns it to the winner.
module alu_scheduler #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [1:0]       r0_op,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_out,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [1:0]       r1_op,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_out,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;    // 1 = r1 has priority on contention
    logic             gnt_q, gnt_d;    // 1 = r1 owns the transaction in flight
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             pick_r1;
    logic             rsp_done;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;

        pick_r1  = r1_valid && (!r0_valid || (RR_EN && ptr_q));
        rsp_done = gnt_q ? r1_rsp_ready : r0_rsp_ready;

        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    r0_ready = !pick_r1;
                    r1_ready = pick_r1;
                    gnt_d    = pick_r1;
                    a_d      = pick_r1 ? r1_a  : r0_a;
                    b_d      = pick_r1 ? r1_b  : r0_b;
                    op_d     = pick_r1 ? r1_op : r0_op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_out;
                state_d = RESP;
            end
            RESP: begin
                r0_rsp_valid = !gnt_q;
                r1_rsp_valid = gnt_q;
                if (rsp_done) begin
                    // The pointer moves only when a response retires, never on a grant.
                    ptr_d   = RR_EN ? !gnt_q : ptr_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples the pre-edge values together.
        // NOTE: operand and result registers are reset too, because the ALU ports must read zero after reset.
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign r0_rsp_out = res_q;
    assign r1_rsp_out = res_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: inputs change and outputs are checked on
// the falling edge; the shared ALU is a small behavioural model.
module tb_alu_scheduler;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [WIDTH-1:0] r0_a, r0_b, r0_rsp_out;
    logic [1:0]       r0_op;
    logic             r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [WIDTH-1:0] r1_a, r1_b, r1_rsp_out;
    logic [1:0]       r1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [1:0]       alu_op;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11;

    always #5 clk = ~clk;

    // Shared ALU outside the scheduler.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ADD: alu_out = alu_a + alu_b;
            SUB: alu_out = alu_a - alu_b;
            AND: alu_out = alu_a & alu_b;
            OR:  alu_out = alu_a | alu_b;
            default: alu_out = '0;
        endcase
    end

    alu_scheduler #(.WIDTH(WIDTH), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_out(r0_rsp_out),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_out(r1_rsp_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .busy(busy)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge; callers drive inputs, then settle().
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r0_valid = 0; r0_a = '0; r0_b = '0; r0_op = ADD; r0_rsp_ready = 0;
        r1_valid = 0; r1_a = '0; r1_b = '0; r1_op = ADD; r1_rsp_ready = 0;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_r0_ready", 32'(r0_ready), 32'd0);
        check("rst_r1_ready", 32'(r1_ready), 32'd0);
        check("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        check("rst_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_out", r0_rsp_out, 32'd0);
        rst = 1'b0;

        // Single op: r0 7-5 with rsp_ready held
        cyc();
        r0_valid = 1; r0_a = 7; r0_b = 5; r0_op = SUB; r0_rsp_ready = 1;
        settle();
        check("single_T_r0_ready", 32'(r0_ready), 32'd1);
        check("single_T_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); r0_valid = 0; settle();
        check("single_T1_alu_op", 32'(alu_op), 32'(SUB));
        check("single_T1_busy", 32'(busy), 32'd1);
        check("single_T1_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        check("single_T1_ready", 32'(r0_ready), 32'd0);
        cyc(); settle();
        check("single_T2_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        check("single_T2_rsp_out", r0_rsp_out, 32'd2);
        check("single_T2_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        cyc(); settle();
        check("single_T3_busy", 32'(busy), 32'd0);
        check("single_T3_alu_hold", alu_a, 32'd7);

        // Contention after reset: r0 first, then r1, then r0 again
        do_reset();
        r0_valid = 1; r0_a = 1; r0_b = 2; r0_op = ADD; r0_rsp_ready = 1;
        r1_valid = 1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = OR; r1_rsp_ready = 1;
        settle();
        check("rr_g1_r0_ready", 32'(r0_ready), 32'd1);
        check("rr_g1_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); settle();
        check("rr_exec_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); settle();
        check("rr_g1_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        check("rr_g1_rsp_out", r0_rsp_out, 32'd3);
        check("rr_g1_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        check("rr_resp_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); settle();
        check("rr_g2_r1_ready", 32'(r1_ready), 32'd1);
        check("rr_g2_r0_ready", 32'(r0_ready), 32'd0);
        cyc(); cyc(); settle();
        check("rr_g2_rsp_valid", 32'(r1_rsp_valid), 32'd1);
        check("rr_g2_rsp_out", r1_rsp_out, 32'hFF);
        check("rr_g2_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        cyc(); settle();
        check("rr_g3_r0_ready", 32'(r0_ready), 32'd1);
        check("rr_g3_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); r0_valid = 0; r1_valid = 0;
        cyc(); settle();
        check("rr_g3_rsp_out", r0_rsp_out, 32'd3);
        check("rr_g3_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        // Pointer now favours r1.

        // Backpressure on r1 while r0 waits
        cyc();
        r1_valid = 1; r1_a = 32'hFFFF0000; r1_b = 32'h12345678; r1_op = AND; r1_rsp_ready = 0;
        settle();
        check("bp_r1_ready", 32'(r1_ready), 32'd1);
        cyc();
        r1_valid = 0;
        r0_valid = 1; r0_a = 32'hFFFFFFFF; r0_b = 32'd1; r0_op = ADD; r0_rsp_ready = 1;
        settle();
        check("bp_exec_r0_ready", 32'(r0_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(); settle();
            check("bp_hold_rsp_valid", 32'(r1_rsp_valid), 32'd1);
            check("bp_hold_rsp_out", r1_rsp_out, 32'h12340000);
            check("bp_hold_r0_ready", 32'(r0_ready), 32'd0);
        end
        cyc(); r1_rsp_ready = 1; settle();
        check("bp_done_rsp_valid", 32'(r1_rsp_valid), 32'd1);
        check("bp_done_r0_ready", 32'(r0_ready), 32'd0);

        // Wrap-around ADD, accepted the cycle after completion
        cyc(); settle();
        check("wrap_add_r0_ready", 32'(r0_ready), 32'd1);
        cyc(); r0_valid = 0;
        cyc(); settle();
        check("wrap_add_rsp_out", r0_rsp_out, 32'd0);
        check("wrap_add_rsp_valid", 32'(r0_rsp_valid), 32'd1);

        // SUB 0-1 with operands changed right after the handshake
        cyc();
        r0_valid = 1; r0_a = 32'd0; r0_b = 32'd1; r0_op = SUB;
        settle();
        check("stab_r0_ready", 32'(r0_ready), 32'd1);
        cyc();
        r0_valid = 0; r0_a = 32'd5; r0_b = 32'd5; r0_op = ADD;
        settle();
        check("stab_alu_a", alu_a, 32'd0);
        check("stab_alu_b", alu_b, 32'd1);
        cyc(); settle();
        check("stab_rsp_out", r0_rsp_out, 32'hFFFFFFFF);
        cyc(); settle();

        // Reset mid-op while r1 holds a response
        r1_valid = 1; r1_a = 32'd10; r1_b = 32'd20; r1_op = ADD; r1_rsp_ready = 0;
        settle();
        check("mid_r1_ready", 32'(r1_ready), 32'd1);
        cyc(); r1_valid = 0;
        cyc(); settle();
        check("mid_rsp_valid_pre", 32'(r1_rsp_valid), 32'd1);
        check("mid_rsp_out_pre", r1_rsp_out, 32'd30);
        rst = 1;
        cyc(); rst = 0; settle();
        check("mid_rsp_valid_post", 32'(r1_rsp_valid), 32'd0);
        check("mid_busy_post", 32'(busy), 32'd0);
        check("mid_alu_a_post", alu_a, 32'd0);
        check("mid_alu_b_post", alu_b, 32'd0);
        check("mid_rsp_out_post", r1_rsp_out, 32'd0);
        // Pointer back at r0: both valid, r0 must win.
        r0_valid = 1; r0_a = 32'hF0F0; r0_b = 32'hFF00; r0_op = AND; r0_rsp_ready = 1;
        r1_valid = 1;
        settle();
        check("mid_fresh_r0_ready", 32'(r0_ready), 32'd1);
        check("mid_fresh_r1_ready", 32'(r1_ready), 32'd0);
        cyc(); r0_valid = 0; r1_valid = 0;
        cyc(); settle();
        check("mid_fresh_rsp_out", r0_rsp_out, 32'hF000);
        check("mid_fresh_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        cyc(); settle();
        check("mid_fresh_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
